// File: rtl/if_id_stage_if.sv
// rtl/if_id_stage_if.sv - IF/ID stage signal bundle: fetch, EX feedback and decode-side outputs
interface if_id_stage_if #(
  parameter int CNT_W = 32
);
  logic             fetch_valid_i;
  logic [31:0]      fetch_PC_i;
  logic [31:0]      fetch_pcPlus4_i;
  logic [31:0]      fetch_instr_i;
  logic             redirect_i;
  logic             ex_MemRead_i;
  logic [4:0]       ex_rd_i;
  logic [31:0]      PC_o;
  logic [31:0]      pcPlus4_o;
  logic [31:0]      instr_o;
  logic             valid_o;
  logic [4:0]       rs1_o;
  logic [4:0]       rs2_o;
  logic             stall_o;
  logic             bubble_o;
  logic [CNT_W-1:0] stall_cnt_o;
  logic [CNT_W-1:0] flush_cnt_o;

  modport master (
    output fetch_valid_i, fetch_PC_i, fetch_pcPlus4_i, fetch_instr_i,
    output redirect_i, ex_MemRead_i, ex_rd_i,
    input  PC_o, pcPlus4_o, instr_o, valid_o, rs1_o, rs2_o,
    input  stall_o, bubble_o, stall_cnt_o, flush_cnt_o
  );

  modport slave (
    input  fetch_valid_i, fetch_PC_i, fetch_pcPlus4_i, fetch_instr_i,
    input  redirect_i, ex_MemRead_i, ex_rd_i,
    output PC_o, pcPlus4_o, instr_o, valid_o, rs1_o, rs2_o,
    output stall_o, bubble_o, stall_cnt_o, flush_cnt_o
  );
endinterface

// File: rtl/if_id_stage.sv
// rtl/if_id_stage.sv - IF/ID pipeline register with load-use hazard detect, redirect squash and perf counters
module if_id_stage #(
  parameter int DROP_CYCLES = 1,
  parameter int CNT_W       = 32
) (
  input logic          clk_i,
  input logic          rst_i,
  if_id_stage_if.slave bus
);
  localparam logic [31:0] NOP = 32'h00000013;
  localparam int DROP_W = (DROP_CYCLES < 1) ? 1 : $clog2(DROP_CYCLES + 1);
  localparam logic [DROP_W-1:0] DROP_LOAD = DROP_W'(DROP_CYCLES);

  logic [31:0]       pc_q, pc_d;
  logic [31:0]       pc_plus4_q, pc_plus4_d;
  logic [31:0]       instr_q, instr_d;
  logic              valid_q, valid_d;
  logic [DROP_W-1:0] drop_cnt_q, drop_cnt_d;
  logic [CNT_W-1:0]  stall_cnt_q, stall_cnt_d;
  logic [CNT_W-1:0]  flush_cnt_q, flush_cnt_d;

  logic [4:0] rs1;
  logic [4:0] rs2;
  logic       hazard;

  assign rs1 = instr_q[19:15];
  assign rs2 = instr_q[24:20];

  // rs2 is compared for every format; the occasional needless stall is accepted.
  assign hazard = valid_q & bus.ex_MemRead_i & (bus.ex_rd_i != 5'd0) &
                  ((bus.ex_rd_i == rs1) | (bus.ex_rd_i == rs2));

  always_comb begin
    pc_d        = pc_q;
    pc_plus4_d  = pc_plus4_q;
    instr_d     = instr_q;
    valid_d     = valid_q;
    drop_cnt_d  = drop_cnt_q;
    stall_cnt_d = stall_cnt_q;
    flush_cnt_d = flush_cnt_q;

    if (bus.redirect_i) begin
      valid_d    = 1'b0;
      instr_d    = NOP;
      drop_cnt_d = DROP_LOAD;
      if (flush_cnt_q != '1) flush_cnt_d = flush_cnt_q + CNT_W'(1);
    end else if (hazard) begin
      if (stall_cnt_q != '1) stall_cnt_d = stall_cnt_q + CNT_W'(1);
    end else if (drop_cnt_q != '0) begin
      // Stale fetch still in flight from the wrong path.
      valid_d    = 1'b0;
      instr_d    = NOP;
      drop_cnt_d = drop_cnt_q - DROP_W'(1);
    end else if (bus.fetch_valid_i) begin
      pc_d       = bus.fetch_PC_i;
      pc_plus4_d = bus.fetch_pcPlus4_i;
      instr_d    = bus.fetch_instr_i;
      valid_d    = 1'b1;
    end else begin
      valid_d = 1'b0;
      instr_d = NOP;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      pc_q        <= '0;
      pc_plus4_q  <= '0;
      instr_q     <= NOP;
      valid_q     <= 1'b0;
      drop_cnt_q  <= '0;
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      pc_q        <= pc_d;
      pc_plus4_q  <= pc_plus4_d;
      instr_q     <= instr_d;
      valid_q     <= valid_d;
      drop_cnt_q  <= drop_cnt_d;
      stall_cnt_q <= stall_cnt_d;
      flush_cnt_q <= flush_cnt_d;
    end
  end

  assign bus.PC_o        = pc_q;
  assign bus.pcPlus4_o   = pc_plus4_q;
  assign bus.instr_o     = instr_q;
  assign bus.valid_o     = valid_q;
  assign bus.rs1_o       = rs1;
  assign bus.rs2_o       = rs2;
  assign bus.stall_o     = hazard & ~bus.redirect_i;
  assign bus.bubble_o    = hazard | bus.redirect_i;
  assign bus.stall_cnt_o = stall_cnt_q;
  assign bus.flush_cnt_o = flush_cnt_q;
endmodule
